jump_ctrl: RTL and testbench
============================

# jump_ctrl

Control-flow unit that drives the program counter's `absjump_en`/`target` inputs. It decodes a per-instruction branch opcode, resolves conditional branches against the ALU zero flag, and maps a short immediate to a full absolute address through a constant target table. It keeps a small hardware return-address stack for call/return, and freezes the program counter on halt or stack fault. It sits between the instruction decoder and the program counter.

## Interface
- `D`, 10, program-counter / address width
- `LUTW`, 3, width of the target-table index (2^LUTW entries)
- `RSD`, 4, return-stack depth (entries)

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted)
- `br_op`  in  3  branch opcode of current instruction (`br_op_e`)
- `zero_flag`  in  1  ALU zero flag for current instruction
- `lut_idx`  in  LUTW  index into target table
- `prog_ctr`  in  D  current program counter value
- `absjump_en`  out  1  load `target` into PC at next edge
- `target`  out  D  absolute jump address
- `done`  out  1  program halted normally
- `stack_err`  out  1  sticky return-stack overflow/underflow fault

## Operation
- Opcodes: NONE=0, JMP=1, BEQZ=2, BNEZ=3, CALL=4, RET=5, HALT=6; 7 is reserved and treated as NONE.
- State machine `st_e`: RUN, HALTED, FAULT. Reset → RUN.
- RUN, outputs (combinational from inputs and state):
  - NONE: `absjump_en`=0, `target`=0.
  - JMP: `absjump_en`=1, `target`=LUT[lut_idx].
  - BEQZ: taken iff `zero_flag`=1. BNEZ: taken iff `zero_flag`=0. If taken, `absjump_en`=1 and `target`=LUT[lut_idx]; else `absjump_en`=0 and `target`=0.
  - CALL, stack not full: `absjump_en`=1, `target`=LUT[lut_idx]; at the edge push (`prog_ctr`+1) mod 2^D.
  - RET, stack not empty: `absjump_en`=1, `target`=top of stack; at the edge pop.
  - HALT: `absjump_en`=1, `target`=`prog_ctr`; at the edge → HALTED.
  - CALL on full stack, or RET on empty stack: `absjump_en`=1, `target`=`prog_ctr`. No push/pop. At the edge set `stack_err`=1 and → FAULT.
- HALTED or FAULT: `br_op` is ignored; `absjump_en`=1, `target`=`prog_ctr` (PC frozen). Only `reset` exits these states.
- `done`=1 iff state is HALTED. `stack_err` is registered and stays set until reset.
- Stack: LIFO with a depth counter 0..RSD. Full when count=RSD, empty when count=0. Entry contents are undefined after reset.

## Timing
- Reset (async assert, sync release is the integrator's job): state=RUN, count=0, `done`=0, `stack_err`=0. While in reset, `absjump_en` and `target` follow RUN decode; the PC is in its own reset at that time.
- Zero-latency decode: `absjump_en`/`target` are valid in the same cycle as `br_op`; the PC captures them at the next edge.
- Push/pop/state updates take effect at the edge ending the instruction cycle. A RET in the cycle right after a CALL returns the just-pushed address.
- `done`/`stack_err` rise one cycle after HALT or the faulting op.
- Reset mid-HALTED or mid-FAULT clears the state immediately (asynchronous); the stack is emptied.

## Structure
- Package `jump_pkg`: `br_op_e`, `st_e`, parameter defaults, `TARGET_LUT` constant array (2^LUTW × D).
- Sub-module `ret_stack` (`clk`, `reset`, `push`, `pop`, `din`, `dout`, `full`, `empty`). It ignores push when full and pop when empty. `jump_ctrl` holds only the FSM and decode.

## Test plan
- Reset, then NONE for 3 cycles → `absjump_en`=0, `done`=0, `stack_err`=0.
- JMP with lut_idx=2 → `absjump_en`=1, `target`=TARGET_LUT[2]. BEQZ with zero_flag=0 → `absjump_en`=0. BNEZ with zero_flag=0 → taken.
- CALL at `prog_ctr`=1023, then RET → push 0; RET gives `target`=0 (wrap) and the stack is empty afterwards.
- Five nested CALLs (RSD=4) → 5th: `target`=`prog_ctr`, `stack_err`=1 next cycle, FAULT holds the PC thereafter.
- RET on empty stack after reset → `stack_err`=1. Then HALT is ignored (state stays FAULT, `done`=0).
- HALT → `done`=1 next cycle, PC frozen for 10 cycles despite JMP inputs. Async `reset`=0 mid-cycle → `done`=0 immediately, RUN resumes.

Source files
------------

// File: rtl/jump_pkg.sv
// Shared types and constants for the jump control unit: opcodes, FSM states,
// default sizes and the constant absolute-target table.
package jump_pkg;

    localparam int unsigned D_DEF    = 10;
    localparam int unsigned LUTW_DEF = 3;
    localparam int unsigned RSD_DEF  = 4;

    typedef enum logic [2:0] {
        NONE = 3'd0,
        JMP  = 3'd1,
        BEQZ = 3'd2,
        BNEZ = 3'd3,
        CALL = 3'd4,
        RET  = 3'd5,
        HALT = 3'd6,
        RSVD = 3'd7
    } br_op_e;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        FAULT  = 2'd2
    } st_e;

    // Absolute addresses selected by lut_idx
    localparam logic [D_DEF-1:0] TARGET_LUT [2**LUTW_DEF] = '{
        10'd16, 10'd64, 10'd128, 10'd200, 10'd300, 10'd512, 10'd777, 10'd1000
    };

endpackage

// File: rtl/ret_stack.sv
// Hardware return-address stack: LIFO with a 0..RSD depth counter.
// Push on full and pop on empty are ignored.
module ret_stack
    import jump_pkg::*;
#(
    parameter int unsigned D   = D_DEF,
    parameter int unsigned RSD = RSD_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [D-1:0] din,
    output logic [D-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int unsigned CW = $clog2(RSD + 1);
    localparam int unsigned PW = (RSD > 1) ? $clog2(RSD) : 1;

    logic [D-1:0]  mem_q [RSD];
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [PW-1:0] top_idx;
    logic [PW-1:0] wr_idx;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == CW'(RSD));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty && !do_push;
    assign wr_idx  = PW'(count_q);
    assign top_idx = PW'(count_q - CW'(1));
    assign dout    = mem_q[top_idx];

    always_comb begin
        count_d = count_q;
        if (do_push) begin
            count_d = count_q + CW'(1);
        end else if (do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Entry storage is not reset; only the depth counter defines validity
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/jump_ctrl.sv
// Control-flow unit: decodes branch opcodes into PC absjump_en/target,
// manages call/return via ret_stack, and freezes the PC on halt or fault.
module jump_ctrl
    import jump_pkg::*;
#(
    parameter int unsigned D    = D_DEF,
    parameter int unsigned LUTW = LUTW_DEF,
    parameter int unsigned RSD  = RSD_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      br_op,
    input  logic            zero_flag,
    input  logic [LUTW-1:0] lut_idx,
    input  logic [D-1:0]    prog_ctr,
    output logic            absjump_en,
    output logic [D-1:0]    target,
    output logic            done,
    output logic            stack_err
);

    st_e          st_q;
    st_e          st_d;
    logic         done_q;
    logic         err_q;
    logic         fault_c;
    logic         push_c;
    logic         pop_c;
    logic [D-1:0] ret_addr;
    logic         stk_full;
    logic         stk_empty;
    logic [D-1:0] lut_val;
    logic [D-1:0] link_addr;
    br_op_e       op;

    assign op        = br_op_e'(br_op);
    assign lut_val   = D'(TARGET_LUT[lut_idx]);
    assign link_addr = D'(prog_ctr + D'(1));

    ret_stack #(
        .D   (D),
        .RSD (RSD)
    ) u_ret_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push_c),
        .pop   (pop_c),
        .din   (link_addr),
        .dout  (ret_addr),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // Zero-latency decode and next-state selection
    always_comb begin
        absjump_en = 1'b0;
        target     = '0;
        push_c     = 1'b0;
        pop_c      = 1'b0;
        fault_c    = 1'b0;
        st_d       = st_q;
        case (st_q)
            RUN: begin
                case (op)
                    JMP: begin
                        absjump_en = 1'b1;
                        target     = lut_val;
                    end
                    BEQZ, BNEZ: begin
                        if (zero_flag == (op == BEQZ)) begin
                            absjump_en = 1'b1;
                            target     = lut_val;
                        end
                    end
                    CALL, RET: begin
                        absjump_en = 1'b1;
                        if ((op == CALL) ? stk_full : stk_empty) begin
                            target  = prog_ctr;
                            fault_c = 1'b1;
                            st_d    = FAULT;
                        end else if (op == CALL) begin
                            target = lut_val;
                            push_c = 1'b1;
                        end else begin
                            target = ret_addr;
                            pop_c  = 1'b1;
                        end
                    end
                    HALT: begin
                        absjump_en = 1'b1;
                        target     = prog_ctr;
                        st_d       = HALTED;
                    end
                    default: begin
                        absjump_en = 1'b0;
                        target     = '0;
                    end
                endcase
            end
            default: begin
                absjump_en = 1'b1;
                target     = prog_ctr;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q   <= RUN;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            done_q <= (st_d == HALTED);
            err_q  <= err_q | fault_c;
        end
    end

    assign done      = done_q;
    assign stack_err = err_q;

endmodule

// File: tb/tb_jump_ctrl.sv
// Directed self-checking bench for jump_ctrl (D=10, LUTW=3, RSD=4).
module tb_jump_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] br_op;
    logic       zero_flag;
    logic [2:0] lut_idx;
    logic [9:0] prog_ctr;
    logic       absjump_en;
    logic [9:0] target;
    logic       done;
    logic       stack_err;

    int errors = 0;
    int checks = 0;

    jump_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .br_op      (br_op),
        .zero_flag  (zero_flag),
        .lut_idx    (lut_idx),
        .prog_ctr   (prog_ctr),
        .absjump_en (absjump_en),
        .target     (target),
        .done       (done),
        .stack_err  (stack_err)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [2:0] op, input logic zf, input logic [2:0] idx,
                         input logic [9:0] pc);
        @(negedge clk);
        br_op     = op;
        zero_flag = zf;
        lut_idx   = idx;
        prog_ctr  = pc;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        br_op = 3'd0; zero_flag = 1'b0; lut_idx = 3'd0; prog_ctr = 10'd0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        br_op = 3'd0; zero_flag = 1'b0; lut_idx = 3'd0; prog_ctr = 10'd0;
        #2;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
        checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", stack_err); end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(3'd0, 1'b0, 3'd1, 10'(i));
            checks++; if (absjump_en !== 1'b0 || target !== 10'd0) begin errors++; $display("FAIL none_%0d: got en=%b tgt=%0d want en=0 tgt=0", i, absjump_en, target); end
            checks++; if (done !== 1'b0 || stack_err !== 1'b0) begin errors++; $display("FAIL none_flags_%0d: got done=%b err=%b want 0 0", i, done, stack_err); end
        end
    endtask

    task automatic test_branches();
        drive(3'd1, 1'b0, 3'd2, 10'd5);
        checks++; if (absjump_en !== 1'b1 || target !== 10'd128) begin errors++; $display("FAIL jmp: got en=%b tgt=%0d want en=1 tgt=128", absjump_en, target); end
        drive(3'd2, 1'b0, 3'd3, 10'd6);
        checks++; if (absjump_en !== 1'b0 || target !== 10'd0) begin errors++; $display("FAIL beqz_nt: got en=%b tgt=%0d want en=0 tgt=0", absjump_en, target); end
        drive(3'd2, 1'b1, 3'd5, 10'd7);
        checks++; if (absjump_en !== 1'b1 || target !== 10'd512) begin errors++; $display("FAIL beqz_t: got en=%b tgt=%0d want en=1 tgt=512", absjump_en, target); end
        drive(3'd3, 1'b0, 3'd7, 10'd8);
        checks++; if (absjump_en !== 1'b1 || target !== 10'd1000) begin errors++; $display("FAIL bnez_t: got en=%b tgt=%0d want en=1 tgt=1000", absjump_en, target); end
        drive(3'd3, 1'b1, 3'd4, 10'd9);
        checks++; if (absjump_en !== 1'b0 || target !== 10'd0) begin errors++; $display("FAIL bnez_nt: got en=%b tgt=%0d want en=0 tgt=0", absjump_en, target); end
        drive(3'd7, 1'b1, 3'd6, 10'd10);
        checks++; if (absjump_en !== 1'b0 || target !== 10'd0) begin errors++; $display("FAIL rsvd: got en=%b tgt=%0d want en=0 tgt=0", absjump_en, target); end
    endtask

    task automatic test_back_to_back();
        // Nested call/return must unwind in LIFO order
        drive(3'd4, 1'b0, 3'd0, 10'd100);
        checks++; if (absjump_en !== 1'b1 || target !== 10'd16) begin errors++; $display("FAIL call1: got en=%b tgt=%0d want en=1 tgt=16", absjump_en, target); end
        drive(3'd4, 1'b0, 3'd6, 10'd200);
        checks++; if (target !== 10'd777) begin errors++; $display("FAIL call2: got tgt=%0d want 777", target); end
        drive(3'd5, 1'b0, 3'd0, 10'd500);
        checks++; if (absjump_en !== 1'b1 || target !== 10'd201) begin errors++; $display("FAIL ret1: got en=%b tgt=%0d want en=1 tgt=201", absjump_en, target); end
        drive(3'd5, 1'b0, 3'd0, 10'd501);
        checks++; if (absjump_en !== 1'b1 || target !== 10'd101) begin errors++; $display("FAIL ret2: got en=%b tgt=%0d want en=1 tgt=101", absjump_en, target); end
        drive(3'd0, 1'b0, 3'd0, 10'd502);
        checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b want 0", stack_err); end
    endtask

    task automatic test_call_wrap();
        do_reset();
        drive(3'd4, 1'b0, 3'd1, 10'd1023);
        checks++; if (absjump_en !== 1'b1 || target !== 10'd64) begin errors++; $display("FAIL wrap_call: got en=%b tgt=%0d want en=1 tgt=64", absjump_en, target); end
        drive(3'd5, 1'b0, 3'd0, 10'd64);
        checks++; if (absjump_en !== 1'b1 || target !== 10'd0) begin errors++; $display("FAIL wrap_ret: got en=%b tgt=%0d want en=1 tgt=0", absjump_en, target); end
        // Stack is now empty: a further RET must fault
        drive(3'd5, 1'b0, 3'd0, 10'd33);
        checks++; if (absjump_en !== 1'b1 || target !== 10'd33) begin errors++; $display("FAIL wrap_empty: got en=%b tgt=%0d want en=1 tgt=33", absjump_en, target); end
        drive(3'd0, 1'b0, 3'd0, 10'd34);
        checks++; if (stack_err !== 1'b1) begin errors++; $display("FAIL wrap_err: got %b want 1", stack_err); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            drive(3'd4, 1'b0, 3'd3, 10'(i * 10));
            checks++; if (absjump_en !== 1'b1 || target !== 10'd200) begin errors++; $display("FAIL ovf_call%0d: got en=%b tgt=%0d want en=1 tgt=200", i, absjump_en, target); end
        end
        drive(3'd4, 1'b0, 3'd3, 10'd50);
        checks++; if (absjump_en !== 1'b1 || target !== 10'd50) begin errors++; $display("FAIL ovf_call5: got en=%b tgt=%0d want en=1 tgt=50", absjump_en, target); end
        checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL ovf_err_early: got %b want 0", stack_err); end
        drive(3'd1, 1'b0, 3'd2, 10'd77);
        checks++; if (stack_err !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL ovf_flags: got err=%b done=%b want 1 0", stack_err, done); end
        checks++; if (absjump_en !== 1'b1 || target !== 10'd77) begin errors++; $display("FAIL ovf_hold: got en=%b tgt=%0d want en=1 tgt=77", absjump_en, target); end
        drive(3'd5, 1'b0, 3'd0, 10'd78);
        checks++; if (absjump_en !== 1'b1 || target !== 10'd78) begin errors++; $display("FAIL ovf_hold2: got en=%b tgt=%0d want en=1 tgt=78", absjump_en, target); end
    endtask

    task automatic test_ret_empty();
        do_reset();
        drive(3'd5, 1'b0, 3'd0, 10'd5);
        checks++; if (absjump_en !== 1'b1 || target !== 10'd5) begin errors++; $display("FAIL rete: got en=%b tgt=%0d want en=1 tgt=5", absjump_en, target); end
        drive(3'd6, 1'b0, 3'd0, 10'd6);
        checks++; if (stack_err !== 1'b1) begin errors++; $display("FAIL rete_err: got %b want 1", stack_err); end
        checks++; if (absjump_en !== 1'b1 || target !== 10'd6) begin errors++; $display("FAIL rete_halt: got en=%b tgt=%0d want en=1 tgt=6", absjump_en, target); end
        drive(3'd0, 1'b0, 3'd0, 10'd7);
        checks++; if (done !== 1'b0 || stack_err !== 1'b1) begin errors++; $display("FAIL rete_fault: got done=%b err=%b want 0 1", done, stack_err); end
    endtask

    task automatic test_halt();
        do_reset();
        drive(3'd6, 1'b0, 3'd0, 10'd300);
        checks++; if (absjump_en !== 1'b1 || target !== 10'd300 || done !== 1'b0) begin errors++; $display("FAIL halt: got en=%b tgt=%0d done=%b want 1 300 0", absjump_en, target, done); end
        for (int i = 0; i < 10; i++) begin
            drive(3'd1, 1'b0, 3'd2, 10'd300);
            checks++; if (absjump_en !== 1'b1 || target !== 10'd300 || done !== 1'b1) begin errors++; $display("FAIL halt_hold%0d: got en=%b tgt=%0d done=%b want 1 300 1", i, absjump_en, target, done); end
        end
        checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL halt_err: got %b want 0", stack_err); end
        // Asynchronous reset in the middle of a cycle
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL async_done: got %b want 0", done); end
        checks++; if (absjump_en !== 1'b1 || target !== 10'd128) begin errors++; $display("FAIL async_run: got en=%b tgt=%0d want en=1 tgt=128", absjump_en, target); end
        @(negedge clk);
        reset = 1'b1;
        drive(3'd1, 1'b0, 3'd3, 10'd301);
        checks++; if (absjump_en !== 1'b1 || target !== 10'd200) begin errors++; $display("FAIL resume: got en=%b tgt=%0d want en=1 tgt=200", absjump_en, target); end
        drive(3'd0, 1'b0, 3'd0, 10'd200);
        checks++; if (done !== 1'b0 || absjump_en !== 1'b0) begin errors++; $display("FAIL resume2: got done=%b en=%b want 0 0", done, absjump_en); end
    endtask

    initial begin
        test_reset();
        test_branches();
        test_back_to_back();
        test_call_wrap();
        test_overflow();
        test_ret_empty();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
